subtractor_pipelined: RTL and testbench



---
 rtl/subtractor_pipelined_pkg.sv | 32 +++
 rtl/subtractor_pipelined_sub_chunk_stage.sv | 40 ++++
 rtl/subtractor_pipelined.sv | 148 ++++++++++++++
 tb/tb_subtractor_pipelined.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pipelined_pkg.sv
// Shared configuration for the chunked, borrow-rippling pipelined subtractor.
package subtractor_pipelined_pkg;

  localparam int unsigned SUB_WIDTH  = 120;
  localparam int unsigned SUB_CHUNK  = 30;
  localparam int unsigned SUB_STAGES = SUB_WIDTH / SUB_CHUNK;

  // Legal configuration: non-zero chunk that tiles the operand exactly.
  function automatic bit cfg_ok(input int unsigned w, input int unsigned c);
    if (c == 0) return 1'b0;
    return (w >= c) && ((w % c) == 0);
  endfunction

  localparam bit SUB_CFG_OK = cfg_ok(SUB_WIDTH, SUB_CHUNK);

  // Bit offset of operand level k (k >= 1) inside the packed operand skew store.
  // Level k keeps chunks k..STAGES-1, i.e. w - k*c bits.
  function automatic int unsigned op_off(input int unsigned k, input int unsigned w,
                                         input int unsigned c);
    return (k - 1) * w - (c * (k - 1) * k) / 2;
  endfunction

  // Bit offset of result deskew level k (k >= 1); level k keeps k*c result bits.
  function automatic int unsigned res_off(input int unsigned k, input int unsigned c);
    return (c * (k - 1) * k) / 2;
  endfunction

  function automatic int unsigned max1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/subtractor_pipelined_sub_chunk_stage.sv
// One CHUNK-bit subtract slice: d = a - b - borrow_in, registered with its borrow and valid.
module sub_chunk_stage
  import subtractor_pipelined_pkg::*;
#(
  parameter int unsigned CHUNK = SUB_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             borrow_in,
  input  logic             valid_in,
  output logic [CHUNK-1:0] d_chunk,
  output logic             borrow_out,
  output logic             valid_out
);

  logic [CHUNK:0] w_sum;

  // a + ~b + !borrow_in; the top bit is the carry, whose complement is the borrow.
  always_comb begin
    w_sum = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, ~borrow_in};
  end

  // Register the slice result; data holds when no operation passes through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_chunk    <= '0;
      borrow_out <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        d_chunk    <= w_sum[CHUNK-1:0];
        borrow_out <= ~w_sum[CHUNK];
      end
    end
  end

endmodule

// File: rtl/subtractor_pipelined.sv
// Pipelined WIDTH-bit subtractor: borrow ripples one CHUNK per clock, one op per cycle.
module subtractor_pipelined
  import subtractor_pipelined_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH,
  parameter int unsigned CHUNK = SUB_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH:0]   diff
);

  localparam int unsigned STAGES   = WIDTH / CHUNK;
  localparam int unsigned OP_BITS  = max1(op_off(STAGES, WIDTH, CHUNK));
  localparam int unsigned RES_BITS = max1(res_off(STAGES, CHUNK));

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("subtractor_pipelined: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_v0;
  logic [STAGES:0]   w_v;
  logic [CHUNK-1:0]  w_d [STAGES];
  logic [STAGES-1:0] w_borrow;
  // Triangular skew/deskew stores: each level keeps only the chunks still needed,
  // packed back to back so no register bit is left unused.
  logic [OP_BITS-1:0]  r_a_lvl;
  logic [OP_BITS-1:0]  r_b_lvl;
  logic [RES_BITS-1:0] r_res;
  logic [WIDTH:0]      w_final;
  logic                r_out_valid;
  logic [WIDTH:0]      r_diff;

  // Input capture; operands hold when no operation is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else begin
      r_v0 <= in_valid;
      if (in_valid) begin
        r_a <= a;
        r_b <= b;
      end
    end
  end

  assign w_v[0] = r_v0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned WK = WIDTH - k * CHUNK;
    logic [WK-1:0] w_a_k;
    logic [WK-1:0] w_b_k;
    logic          w_bin;

    if (k == 0) begin : g_first
      assign w_a_k = r_a;
      assign w_b_k = r_b;
      assign w_bin = 1'b0;
    end else begin : g_rest
      localparam int unsigned OFF = op_off(k, WIDTH, CHUNK);
      assign w_a_k = r_a_lvl[OFF +: WK];
      assign w_b_k = r_b_lvl[OFF +: WK];
      assign w_bin = w_borrow[k-1];
    end

    sub_chunk_stage #(.CHUNK(CHUNK)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_chunk    (w_a_k[CHUNK-1:0]),
      .b_chunk    (w_b_k[CHUNK-1:0]),
      .borrow_in  (w_bin),
      .valid_in   (w_v[k]),
      .d_chunk    (w_d[k]),
      .borrow_out (w_borrow[k]),
      .valid_out  (w_v[k+1])
    );

    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned NOFF = op_off(k + 1, WIDTH, CHUNK);
      // Forward the unprocessed upper operand chunks alongside this stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a_lvl[NOFF +: WK-CHUNK] <= '0;
          r_b_lvl[NOFF +: WK-CHUNK] <= '0;
        end else if (w_v[k]) begin
          r_a_lvl[NOFF +: WK-CHUNK] <= w_a_k[WK-1:CHUNK];
          r_b_lvl[NOFF +: WK-CHUNK] <= w_b_k[WK-1:CHUNK];
        end
      end
    end

    if (k >= 1) begin : g_deskew
      localparam int unsigned ROFF = res_off(k, CHUNK);
      if (k == 1) begin : g_lo
        // Delay chunk 0 result so it lines up with later chunks.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_res[ROFF +: CHUNK] <= '0;
          end else if (w_v[k]) begin
            r_res[ROFF +: CHUNK] <= w_d[0];
          end
        end
      end else begin : g_hi
        localparam int unsigned POFF = res_off(k - 1, CHUNK);
        // Append the newest lower chunk result to the delayed lower results.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_res[ROFF +: k*CHUNK] <= '0;
          end else if (w_v[k]) begin
            r_res[ROFF +: k*CHUNK] <= {w_d[k-1], r_res[POFF +: (k-1)*CHUNK]};
          end
        end
      end
    end
  end

  if (STAGES == 1) begin : g_final_one
    assign w_final = {w_borrow[0], w_d[0]};
  end else begin : g_final_many
    localparam int unsigned LOFF = res_off(STAGES - 1, CHUNK);
    assign w_final = {w_borrow[STAGES-1], w_d[STAGES-1], r_res[LOFF +: (STAGES-1)*CHUNK]};
  end

  // Output register; diff holds its last result between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
    end else begin
      r_out_valid <= w_v[STAGES];
      if (w_v[STAGES]) begin
        r_diff <= w_final;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;

endmodule

// File: tb/tb_subtractor_pipelined.sv
// Self-checking bench: directed table, hand sequences, random stream vs. a queue model.
module tb_subtractor_pipelined;
  import subtractor_pipelined_pkg::*;

  localparam int unsigned W   = SUB_WIDTH;
  localparam int unsigned LAT = SUB_STAGES + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W:0]   diff;

  subtractor_pipelined #(.WIDTH(W), .CHUNK(SUB_CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .diff      (diff)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: queue of results due at (sampling edge + LAT), exact unsigned arithmetic.
  typedef struct {
    int unsigned due;
    logic [W:0]  d;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  bit          started = 0;
  logic [W:0]  last_diff = '0;
  int unsigned pulses = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1;
    if (!rst_n) begin
      q.delete();
      last_diff = '0;
    end else if (in_valid) begin
      q.push_back('{due: cyc + LAT, d: ({1'b0, a} - {1'b0, b})});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (out_valid === 1'b1) pulses++;
      if (q.size() != 0 && q[0].due == cyc) begin
        last_diff = q[0].d;
        void'(q.pop_front());
        check("sb_valid_hi", (W+1)'(out_valid), (W+1)'(1));
        check("sb_diff", diff, last_diff);
      end else begin
        check("sb_valid_lo", (W+1)'(out_valid), (W+1)'(0));
        check("sb_diff_hold", diff, last_diff);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return (W)'(1) << $urandom_range(0, W - 1);
      default: return t[W-1:0];
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  vec_t        vecs[8];
  logic [W:0]  exp_post;
  int unsigned issued;

  initial begin
    vecs[0] = '{a: (W)'(1000), b: (W)'(1), exp: (W+1)'(999)};
    vecs[1] = '{a: '0, b: (W)'(1), exp: '1};
    vecs[2] = '{a: (W)'(1) << 90, b: (W)'(1), exp: ((W+1)'(1) << 90) - (W+1)'(1)};
    vecs[3] = '{a: '1, b: '0, exp: {1'b0, {W{1'b1}}}};
    vecs[4] = '{a: (W)'(123456789), b: (W)'(123456789), exp: '0};
    vecs[5] = '{a: (W)'(5), b: (W)'(7), exp: {1'b1, ~(W)'(1)}};
    vecs[6] = '{a: (W)'(1) << 30, b: (W)'(1), exp: (W+1)'(32'h3FFF_FFFF)};
    vecs[7] = '{a: '0, b: (W)'(1) << 119, exp: {1'b1, (W)'(1) << 119}};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;

    // Reset held with in_valid asserted: nothing may emerge.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rand_op(); b = rand_op();
      tick();
      check("rst_valid", (W+1)'(out_valid), (W+1)'(0));
      check("rst_diff", diff, '0);
    end
    rst_n = 1'b1; in_valid = 1'b0; pulses = 0;
    repeat (LAT + 1) tick();
    check("post_rst_pulses", (W+1)'(pulses), (W+1)'(0));

    // Directed table: exact latency window and value.
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (LAT - 1) tick();
      check("tbl_early", (W+1)'(out_valid), (W+1)'(0));
      tick();
      check("tbl_valid", (W+1)'(out_valid), (W+1)'(1));
      check("tbl_diff", diff, vecs[i].exp);
      tick();
      check("tbl_late", (W+1)'(out_valid), (W+1)'(0));
      check("tbl_hold", diff, vecs[i].exp);
    end

    // Back-to-back stream of 20 with corner pairs mixed in.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; a = rand_op(); b = rand_op();
      if (i == 5)  b = a;
      if (i == 10) begin a = '1; b = '0; end
      if (i == 15) begin a = '0; b = '1; end
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    check("stream_pulses", (W+1)'(pulses), (W+1)'(20));

    // Random traffic with gaps.
    pulses = 0; issued = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      a = rand_op(); b = rand_op();
      if (in_valid) issued++;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    check("rand_pulses", (W+1)'(pulses), (W+1)'(issued));

    // Reset in flight: only the post-reset op may appear.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rand_op(); b = rand_op();
      tick();
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; a = (W)'(77); b = (W)'(80);
    exp_post = {1'b0, a} - {1'b0, b};
    tick();
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    check("midrst_pulses", (W+1)'(pulses), (W+1)'(1));
    check("midrst_diff", diff, exp_post);

    check("queue_drained", (W+1)'(q.size()), (W+1)'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
